hamming_secded_encoder: RTL

- Pipelined SECDED Hamming encoder: the write-side counterpart of the team's 32-bit codeword checker/corrector.
- Accepts 26-bit data words over a valid/ready handshake and emits 32-bit codewords over a second valid/ready handshake.
- Every output codeword satisfies two conditions: the XOR of the indices of all set bits is 0, and the total number of set bits is even.
- Includes a per-word error-injection path for verifying the decoder, plus a count of emitted words.

---
 rtl/hamming_secded_encoder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hamming_secded_encoder.sv
// Two-stage SECDED Hamming encoder: 26-bit data in, 32-bit codeword out.
// The XOR of the indices of the set bits is zero, and the total parity is even.
// Stage 2 can apply single- or double-bit error injection, and a counter
// tracks how many codewords were accepted downstream.
module hamming_secded_encoder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [25:0]      data_in,
   input  logic             inj_en,
   input  logic             inj_double,
   input  logic [4:0]       inj_pos,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      code_out,
   output logic [CNT_W-1:0] word_cnt
);

   // Place the data bits in every position that is not a power of two.
   // Bit 0 stays clear here.
   function automatic logic [31:0] scatter(input logic [25:0] d);
      logic [31:0] cw;
      int unsigned j;
      cw = '0;
      j  = 0;
      for (int unsigned p = 1; p < 32; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p] = d[j];
            j++;
         end
      end
      return cw;
   endfunction

   // Set parity bit 2^k so that the XOR of the set-bit indices becomes zero.
   function automatic logic [31:0] add_hamming(input logic [31:0] cw_in);
      logic [31:0] cw;
      logic        par;
      cw = cw_in;
      for (int unsigned k = 0; k < 5; k++) begin
         par = 1'b0;
         for (int unsigned p = 1; p < 32; p++) begin
            if (((p >> k) & 1) == 1 && (p & (p - 1)) != 0) par ^= cw_in[p];
         end
         cw[1 << k] = par;
      end
      return cw;
   endfunction

   logic              s1_valid_q, s2_valid_q;
   logic [31:0]       s1_code_q, s1_code_d;
   logic              s1_inj_en_q, s1_inj_dbl_q;
   logic [4:0]        s1_inj_pos_q, inj_pos_nxt;
   logic [31:0]       s2_code_q, s2_code_d, full_code, inj_mask;
   logic [CNT_W-1:0]  cnt_q;
   logic              s2_load, in_xfer, out_xfer;

   // Handshake: s2 refills when it is empty or is draining; s1 follows s2.
   always_comb begin
      s2_load  = !s2_valid_q || out_ready;
      in_ready = !s1_valid_q || s2_load;
      in_xfer  = in_valid && in_ready;
      out_xfer = s2_valid_q && out_ready;
   end

   // Stage 1 datapath: scattered data plus the five Hamming parities.
   always_comb begin
      s1_code_d = add_hamming(scatter(data_in));
   end

   // Stage 2 datapath: add overall parity, then flip the injected bit(s).
   always_comb begin
      full_code    = s1_code_q;
      full_code[0] = ^s1_code_q[31:1];
      inj_pos_nxt  = s1_inj_pos_q + 5'd1;
      inj_mask     = '0;
      if (s1_inj_en_q) begin
         inj_mask = 32'd1 << s1_inj_pos_q;
         if (s1_inj_dbl_q) inj_mask = inj_mask | (32'd1 << inj_pos_nxt);
      end
      s2_code_d = full_code ^ inj_mask;
   end

   // Stage 1 register: load on input transfer, empty when s1 moves into s2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_code_q    <= '0;
         s1_inj_en_q  <= 1'b0;
         s1_inj_dbl_q <= 1'b0;
         s1_inj_pos_q <= '0;
      end else if (in_xfer) begin
         s1_valid_q   <= 1'b1;
         s1_code_q    <= s1_code_d;
         s1_inj_en_q  <= inj_en;
         s1_inj_dbl_q <= inj_double;
         s1_inj_pos_q <= inj_pos;
      end else if (s2_load) begin
         s1_valid_q <= 1'b0;
      end
   end

   // Stage 2 register: the codeword is held while downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_code_q  <= '0;
      end else if (s2_load) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) s2_code_q <= s2_code_d;
      end
   end

   // Emitted-word counter that wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (out_xfer) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign out_valid = s2_valid_q;
   assign code_out  = s2_code_q;
   assign word_cnt  = cnt_q;

endmodule
